// File: rtl/ace_ic_pkg.sv
// Shared types and constants for the single-port ACE interconnect responder.
// Holds the FSM state encoding, snoop type codes and small helper functions.
package ace_ic_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_WAIT,
        MEM_WR,
        B_RESP,
        SNOOP_AC,
        SNOOP_CR,
        SNOOP_CD,
        MEM_RD,
        R_RESP
    } ace_ic_state_e;

    localparam logic [1:0] SNP_NOSNOOP    = 2'b00;
    localparam logic [1:0] SNP_READSHARED = 2'b01;
    localparam logic [1:0] SNP_MAKEUNIQUE = 2'b10;

    // The reserved encoding 2'b11 behaves exactly like ReadNoSnoop.
    function automatic logic [1:0] norm_snoop(input logic [1:0] s);
        return (s == 2'b11) ? SNP_NOSNOOP : s;
    endfunction

    function automatic int unsigned lat_width(input int unsigned lat);
        return (lat == 0) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ace_ic_lat_counter.sv
// Memory latency timer shared by the read and write memory phases.
// start loads 1; done is high once the count has reached MEM_LAT.
module ace_ic_lat_counter
    import ace_ic_pkg::*;
#(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);

    localparam int unsigned CW = lat_width(MEM_LAT);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its inputs, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= CW'(1);
        end else if (cnt != CW'(MEM_LAT)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign done = (cnt == CW'(MEM_LAT));

endmodule

// File: rtl/ace_interconnect_responder.sv
// Responder end of a cache-side ACE link: serves reads (with optional peer snoop)
// and write-cleans from one master, one transaction at a time, as a Moore FSM.
module ace_interconnect_responder
    import ace_ic_pkg::*;
#(
    parameter int unsigned MEM_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       AR_VALID,
    output logic       AR_READY,
    input  logic [1:0] ar_snoop,
    output logic       R_VALID,
    input  logic       R_READY,
    output logic       R_okay,
    input  logic       AW_VALID,
    output logic       AW_READY,
    input  logic       W_VALID,
    output logic       W_READY,
    output logic       B_VALID,
    input  logic       B_READY,
    output logic       B_okay,
    output logic       AC_VALID,
    input  logic       AC_READY,
    output logic [1:0] ac_snoop,
    input  logic       CR_VALID,
    output logic       CR_READY,
    input  logic       cr_data_transfer,
    input  logic       cr_error,
    input  logic       CD_VALID,
    output logic       CD_READY,
    output logic       busy
);

    localparam bit BYPASS = (MEM_LAT == 0);

    ace_ic_state_e state_q, state_d;
    logic [1:0]    snoop_q;
    logic          err_q;
    logic          ready_q;
    logic          lat_start;
    logic          lat_done;
    logic [1:0]    ar_type;

    assign ar_type = norm_snoop(ar_snoop);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ready_q) begin
                    if (AW_VALID) begin
                        state_d = W_WAIT;
                    end else if (AR_VALID) begin
                        if (ar_type == SNP_READSHARED || ar_type == SNP_MAKEUNIQUE) begin
                            state_d = SNOOP_AC;
                        end else begin
                            state_d = BYPASS ? R_RESP : MEM_RD;
                        end
                    end
                end
            end
            W_WAIT:   if (W_VALID)  state_d = BYPASS ? B_RESP : MEM_WR;
            MEM_WR:   if (lat_done) state_d = B_RESP;
            B_RESP:   if (B_READY)  state_d = IDLE;
            SNOOP_AC: if (AC_READY) state_d = SNOOP_CR;
            SNOOP_CR: begin
                if (CR_VALID) begin
                    if (cr_data_transfer) begin
                        state_d = SNOOP_CD;
                    end else if (snoop_q == SNP_READSHARED) begin
                        state_d = BYPASS ? R_RESP : MEM_RD;
                    end else begin
                        state_d = R_RESP;
                    end
                end
            end
            SNOOP_CD: if (CD_VALID) state_d = R_RESP;
            MEM_RD:   if (lat_done) state_d = R_RESP;
            R_RESP:   if (R_READY)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // ready_q holds the address channels closed for the first cycle after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            snoop_q <= SNP_NOSNOOP;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (state_q == IDLE && ready_q && !AW_VALID && AR_VALID) begin
                snoop_q <= ar_type;
            end
            if (state_q == SNOOP_CR && CR_VALID) begin
                err_q <= cr_error;
            end else if (state_q == R_RESP && R_READY) begin
                err_q <= 1'b0;
            end
        end
    end

    assign lat_start = (state_d == MEM_RD || state_d == MEM_WR) && (state_d != state_q);

    ace_ic_lat_counter #(
        .MEM_LAT(MEM_LAT)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .start(lat_start),
        .done (lat_done)
    );

    assign AR_READY = (state_q == IDLE) && ready_q;
    assign AW_READY = (state_q == IDLE) && ready_q;
    assign W_READY  = (state_q == W_WAIT);
    assign B_VALID  = (state_q == B_RESP);
    assign B_okay   = (state_q == B_RESP);
    assign AC_VALID = (state_q == SNOOP_AC);
    assign ac_snoop = snoop_q;
    assign CR_READY = (state_q == SNOOP_CR);
    assign CD_READY = (state_q == SNOOP_CD);
    assign R_VALID  = (state_q == R_RESP);
    assign R_okay   = (state_q == R_RESP) && !err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ace_interconnect_responder.sv
// Bench for ace_interconnect_responder: MEM_LAT=4 and MEM_LAT=0 instances on shared
// inputs; expected cycle timing is computed arithmetically from the channel rules.
module tb_ace_interconnect_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       AR_VALID, R_READY, AW_VALID, W_VALID, B_READY, AC_READY;
    logic       CR_VALID, cr_data_transfer, cr_error, CD_VALID;
    logic [1:0] ar_snoop;

    logic       AR_READY, R_VALID, R_okay, AW_READY, W_READY, B_VALID, B_okay;
    logic       AC_VALID, CR_READY, CD_READY, busy;
    logic [1:0] ac_snoop;

    logic       z_AR_READY, z_R_VALID, z_R_okay, z_AW_READY, z_W_READY, z_B_VALID, z_B_okay;
    logic       z_AC_VALID, z_CR_READY, z_CD_READY, z_busy;
    logic [1:0] z_ac_snoop;

    ace_interconnect_responder #(.MEM_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_READY(AR_READY), .ar_snoop(ar_snoop),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_okay(R_okay),
        .AW_VALID(AW_VALID), .AW_READY(AW_READY), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_READY(B_READY), .B_okay(B_okay),
        .AC_VALID(AC_VALID), .AC_READY(AC_READY), .ac_snoop(ac_snoop),
        .CR_VALID(CR_VALID), .CR_READY(CR_READY),
        .cr_data_transfer(cr_data_transfer), .cr_error(cr_error),
        .CD_VALID(CD_VALID), .CD_READY(CD_READY), .busy(busy)
    );

    ace_interconnect_responder #(.MEM_LAT(0)) dut_z (
        .clk(clk), .rst(rst),
        .AR_VALID(AR_VALID), .AR_READY(z_AR_READY), .ar_snoop(ar_snoop),
        .R_VALID(z_R_VALID), .R_READY(R_READY), .R_okay(z_R_okay),
        .AW_VALID(AW_VALID), .AW_READY(z_AW_READY), .W_VALID(W_VALID), .W_READY(z_W_READY),
        .B_VALID(z_B_VALID), .B_READY(B_READY), .B_okay(z_B_okay),
        .AC_VALID(z_AC_VALID), .AC_READY(AC_READY), .ac_snoop(z_ac_snoop),
        .CR_VALID(CR_VALID), .CR_READY(z_CR_READY),
        .cr_data_transfer(cr_data_transfer), .cr_error(cr_error),
        .CD_VALID(CD_VALID), .CD_READY(z_CD_READY), .busy(z_busy)
    );

    bit use_z;
    logic       o_ar_ready, o_aw_ready, o_w_ready, o_b_valid, o_b_okay, o_r_valid, o_r_okay;
    logic       o_ac_valid, o_cr_ready, o_cd_ready, o_busy;
    logic [1:0] o_ac_snoop;

    assign o_ar_ready = use_z ? z_AR_READY : AR_READY;
    assign o_aw_ready = use_z ? z_AW_READY : AW_READY;
    assign o_w_ready  = use_z ? z_W_READY  : W_READY;
    assign o_b_valid  = use_z ? z_B_VALID  : B_VALID;
    assign o_b_okay   = use_z ? z_B_okay   : B_okay;
    assign o_r_valid  = use_z ? z_R_VALID  : R_VALID;
    assign o_r_okay   = use_z ? z_R_okay   : R_okay;
    assign o_ac_valid = use_z ? z_AC_VALID : AC_VALID;
    assign o_ac_snoop = use_z ? z_ac_snoop : ac_snoop;
    assign o_cr_ready = use_z ? z_CR_READY : CR_READY;
    assign o_cd_ready = use_z ? z_CD_READY : CD_READY;
    assign o_busy     = use_z ? z_busy     : busy;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        AR_VALID = 0; ar_snoop = 0; R_READY = 0; AW_VALID = 0; W_VALID = 0; B_READY = 0;
        AC_READY = 0; CR_VALID = 0; cr_data_transfer = 0; cr_error = 0; CD_VALID = 0;
    endtask

    task automatic do_reset();
        rst = 1; clear_inputs();
        step(); step();
        rst = 0;
        step();
    endtask

    // Read transaction; a/c/d/rr are the cycles (AR handshake = 0) from which
    // AC_READY, CR_VALID, CD_VALID and R_READY are held high.
    task automatic do_read(input logic [1:0] snp, input bit dt, input bit er,
                           input int a, input int c, input int d, input int rr, input string tag);
        int L, t_ac, t_cr, t_cd, rise, t_r, t, k;
        int r_first, ac_first, ac_cnt, cd_cnt, r_cnt;
        logic [1:0] eff, ac_type_obs;
        logic r_ok_obs;
        bit snooping, exp_ok, done;
        k = 0;
        while (!o_ar_ready && k < 50) begin step(); k++; end
        n_checks++;
        if (o_ar_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s idle_wait: AR_READY=%b expected 1", tag, o_ar_ready);
            return;
        end
        L = use_z ? 0 : 4;
        eff = (snp == 2'b11) ? 2'b00 : snp;
        snooping = (eff != 2'b00);
        t_ac = 0; t_cr = 0; t_cd = 0;
        if (snooping) begin
            t_ac = mx(1, a);
            t_cr = mx(t_ac + 1, c);
            exp_ok = !er;
            if (dt) begin
                t_cd = mx(t_cr + 1, d);
                rise = t_cd + 1;
            end else if (eff == 2'b01) begin
                rise = t_cr + 1 + L;
            end else begin
                rise = t_cr + 1;
            end
        end else begin
            rise = 1 + L;
            exp_ok = 1'b1;
        end
        t_r = mx(rise, rr);

        AW_VALID = 0;
        t = 0; done = 0; r_first = -1; ac_first = -1; ac_cnt = 0; cd_cnt = 0; r_cnt = 0;
        r_ok_obs = 1'bx; ac_type_obs = 2'bxx;
        while (!done && t < 300) begin
            if (o_r_valid && r_first < 0) begin r_first = t; r_ok_obs = o_r_okay; end
            if (o_ac_valid && ac_first < 0) begin ac_first = t; ac_type_obs = o_ac_snoop; end
            ac_cnt += int'(o_ac_valid);
            cd_cnt += int'(o_cd_ready);
            r_cnt  += int'(o_r_valid);
            AR_VALID = (t == 0); ar_snoop = snp;
            AC_READY = (t >= a); CR_VALID = (t >= c); cr_data_transfer = dt; cr_error = er;
            CD_VALID = (t >= d); R_READY = (t >= rr);
            if (o_r_valid && R_READY) done = 1;
            step(); t++;
        end

        n_checks++;
        if (!done) begin n_fail++; $display("FAIL %s r_timeout: no R handshake in %0d cycles", tag, t); end
        n_checks++;
        if (r_first != rise) begin n_fail++; $display("FAIL %s r_rise: got cycle %0d expected %0d", tag, r_first, rise); end
        n_checks++;
        if (r_ok_obs !== exp_ok) begin n_fail++; $display("FAIL %s r_okay: got %b expected %b", tag, r_ok_obs, exp_ok); end
        n_checks++;
        if (r_cnt != t_r - rise + 1) begin n_fail++; $display("FAIL %s r_hold: got %0d cycles expected %0d", tag, r_cnt, t_r - rise + 1); end
        n_checks++;
        if (ac_cnt != t_ac) begin n_fail++; $display("FAIL %s ac_cycles: got %0d expected %0d", tag, ac_cnt, t_ac); end
        if (snooping) begin
            n_checks++;
            if (ac_first != 1 || ac_type_obs !== eff) begin
                n_fail++; $display("FAIL %s ac_start: got cycle %0d type %b expected cycle 1 type %b", tag, ac_first, ac_type_obs, eff);
            end
        end
        n_checks++;
        if (cd_cnt != ((snooping && dt) ? t_cd - t_cr : 0)) begin
            n_fail++; $display("FAIL %s cd_ready_cycles: got %0d expected %0d", tag, cd_cnt, (snooping && dt) ? t_cd - t_cr : 0);
        end
        n_checks++;
        if (o_r_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s r_release: R_VALID=%b busy=%b expected 0 0", tag, o_r_valid, o_busy);
        end
        clear_inputs();
    endtask

    // Write transaction; w/b are the cycles (AW handshake = 0) from which W_VALID
    // and B_READY are held high. AR_VALID is left as the caller set it.
    task automatic do_write(input int w, input int b, input string tag);
        int L, t_w, rise, t_b, t, k;
        int b_first, b_cnt, wr_cnt, rv_cnt;
        logic b_ok_obs, ar_ready_c1;
        bit done;
        k = 0;
        while (!o_aw_ready && k < 50) begin step(); k++; end
        n_checks++;
        if (o_aw_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s idle_wait: AW_READY=%b expected 1", tag, o_aw_ready);
            return;
        end
        L = use_z ? 0 : 4;
        t_w = mx(1, w);
        rise = t_w + 1 + L;
        t_b = mx(rise, b);

        t = 0; done = 0; b_first = -1; b_cnt = 0; wr_cnt = 0; rv_cnt = 0;
        b_ok_obs = 1'bx; ar_ready_c1 = 1'bx;
        while (!done && t < 300) begin
            if (o_b_valid && b_first < 0) begin b_first = t; b_ok_obs = o_b_okay; end
            if (t == 1) ar_ready_c1 = o_ar_ready;
            b_cnt  += int'(o_b_valid);
            wr_cnt += int'(o_w_ready);
            rv_cnt += int'(o_r_valid);
            AW_VALID = (t == 0); W_VALID = (t >= w); B_READY = (t >= b);
            if (o_b_valid && B_READY) done = 1;
            step(); t++;
        end

        n_checks++;
        if (!done) begin n_fail++; $display("FAIL %s b_timeout: no B handshake in %0d cycles", tag, t); end
        n_checks++;
        if (b_first != rise) begin n_fail++; $display("FAIL %s b_rise: got cycle %0d expected %0d", tag, b_first, rise); end
        n_checks++;
        if (b_ok_obs !== 1'b1) begin n_fail++; $display("FAIL %s b_okay: got %b expected 1", tag, b_ok_obs); end
        n_checks++;
        if (b_cnt != t_b - rise + 1) begin n_fail++; $display("FAIL %s b_hold: got %0d cycles expected %0d", tag, b_cnt, t_b - rise + 1); end
        n_checks++;
        if (wr_cnt != t_w) begin n_fail++; $display("FAIL %s w_ready_cycles: got %0d expected %0d", tag, wr_cnt, t_w); end
        n_checks++;
        if (rv_cnt != 0 || ar_ready_c1 !== 1'b0) begin
            n_fail++; $display("FAIL %s read_blocked: R_VALID cycles %0d AR_READY@1=%b expected 0 0", tag, rv_cnt, ar_ready_c1);
        end
        n_checks++;
        if (o_b_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL %s b_release: B_VALID=%b busy=%b expected 0 0", tag, o_b_valid, o_busy);
        end
        AW_VALID = 0; W_VALID = 0; B_READY = 0;
    endtask

    task automatic test_reset();
        logic [10:0] v, vz;
        rst = 1; clear_inputs();
        step(); step();
        v  = {AR_READY, AW_READY, W_READY, B_VALID, AC_VALID, CR_READY, CD_READY, R_VALID, busy, ac_snoop};
        vz = {z_AR_READY, z_AW_READY, z_W_READY, z_B_VALID, z_AC_VALID, z_CR_READY, z_CD_READY, z_R_VALID, z_busy, z_ac_snoop};
        n_checks++;
        if (v !== '0 || vz !== '0) begin n_fail++; $display("FAIL reset_outputs: got %b / %b expected all 0", v, vz); end
        rst = 0;
        step();
        n_checks++;
        if ({AR_READY, AW_READY, busy} !== 3'b110 || {z_AR_READY, z_AW_READY, z_busy} !== 3'b110) begin
            n_fail++; $display("FAIL reset_release: AR/AW/busy got %b %b %b expected 1 1 0", AR_READY, AW_READY, busy);
        end
    endtask

    task automatic test_write();
        do_write(1, 9, "write_bstall");
        do_write(3, 0, "write_wstall");
    endtask

    task automatic test_read_shared();
        do_read(2'b01, 1'b0, 1'b0, 0, 0, 0, 0, "rs_miss");
        do_read(2'b01, 1'b1, 1'b0, 0, 0, 8, 0, "rs_hit_cdstall");
        do_read(2'b00, 1'b0, 1'b0, 0, 0, 0, 3, "nosnoop_rstall");
        do_read(2'b11, 1'b1, 1'b1, 0, 0, 0, 0, "reserved_type");
    endtask

    task automatic test_make_unique_err();
        do_read(2'b10, 1'b0, 1'b1, 2, 5, 0, 0, "mu_err");
        do_read(2'b00, 1'b0, 1'b0, 0, 0, 0, 0, "after_err");
    endtask

    task automatic test_priority();
        AR_VALID = 1; ar_snoop = 2'b00;
        do_write(0, 2, "prio_write");
        do_read(2'b00, 1'b0, 1'b0, 0, 0, 0, 0, "prio_read");
    endtask

    task automatic test_lat0();
        use_z = 1;
        do_reset();
        do_read(2'b00, 1'b0, 1'b0, 0, 0, 0, 0, "lat0_nosnoop");
        do_read(2'b01, 1'b0, 1'b0, 0, 0, 0, 0, "lat0_rs_miss");
        do_write(1, 0, "lat0_write");
        use_z = 0;
        do_reset();
    endtask

    task automatic test_reset_abort();
        int seen;
        do_reset();
        AR_VALID = 1; ar_snoop = 2'b01; AC_READY = 1;
        step();
        AR_VALID = 0;
        step();
        n_checks++;
        if (CR_READY !== 1'b1) begin n_fail++; $display("FAIL abort_in_cr: CR_READY=%b expected 1", CR_READY); end
        rst = 1;
        step();
        n_checks++;
        if ({AR_READY, AW_READY, W_READY, B_VALID, B_okay, AC_VALID, CR_READY, CD_READY, R_VALID, R_okay, busy, ac_snoop} !== '0) begin
            n_fail++; $display("FAIL abort_outputs: busy=%b CR_READY=%b ac_snoop=%b expected all 0", busy, CR_READY, ac_snoop);
        end
        rst = 0; CR_VALID = 1; cr_data_transfer = 1; CD_VALID = 1; R_READY = 1; B_READY = 1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen += int'(R_VALID) + int'(B_VALID) + int'(busy);
        end
        n_checks++;
        if (seen != 0 || AR_READY !== 1'b1) begin
            n_fail++; $display("FAIL abort_no_response: activity %0d AR_READY=%b expected 0 1", seen, AR_READY);
        end
        clear_inputs();
        do_read(2'b01, 1'b0, 1'b0, 0, 0, 0, 0, "abort_recover");
    endtask

    task automatic test_random(input int n, input bit z);
        use_z = z;
        do_reset();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_write(int'($urandom_range(0, 4)), int'($urandom_range(0, 10)), "rand_write");
            end else begin
                do_read(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 4)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 8)), int'($urandom_range(0, 6)), "rand_read");
            end
        end
        use_z = 0;
        do_reset();
    endtask

    initial begin
        use_z = 0;
        clear_inputs();
        test_reset();
        test_write();
        test_read_shared();
        test_make_unique_err();
        test_priority();
        test_lat0();
        test_reset_abort();
        test_random(24, 1'b0);
        test_random(12, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "global timeout");
    end

endmodule
